// File: rtl/exibe_sequencia_pkg.sv
// exibe_sequencia shared types
// state codes double as hexa7seg debug digits
package exibe_sequencia_pkg;

  localparam logic [3:0] COD_INICIAL = 4'h0;
  localparam logic [3:0] COD_PREPARA = 4'h1;
  localparam logic [3:0] COD_ACENDE  = 4'h2;
  localparam logic [3:0] COD_APAGA   = 4'h3;
  localparam logic [3:0] COD_PROXIMO = 4'h4;
  localparam logic [3:0] COD_FIM     = 4'hF;

  localparam int T_ON_PADRAO  = 50_000_000;
  localparam int T_OFF_PADRAO = 25_000_000;
  localparam int TMR_W_PADRAO = 26;

  typedef enum logic [3:0] {
    INICIAL = COD_INICIAL,
    PREPARA = COD_PREPARA,
    ACENDE  = COD_ACENDE,
    APAGA   = COD_APAGA,
    PROXIMO = COD_PROXIMO,
    FIM     = COD_FIM
  } estado_t;

endpackage

// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia bus: game UC / ROM side
// master drives requests and ROM data
interface exibe_sequencia_if;

  logic       mostrar;
  logic [3:0] limite;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output mostrar,
    output limite,
    output dado_mem,
    input  endereco,
    input  leds,
    input  exibindo,
    input  pronto,
    input  db_estado
  );

  modport slave (
    input  mostrar,
    input  limite,
    input  dado_mem,
    output endereco,
    output leds,
    output exibindo,
    output pronto,
    output db_estado
  );

endinterface

// File: rtl/exibe_sequencia_temporizador.sv
// modulo-M up-counter with sync clear
// fim flags the last count (M-1)
module exibe_sequencia_temporizador #(
  parameter int M = 2,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  assign fim = (q == W'(M - 1));

  // count while enabled, wrap after M-1
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/exibe_sequencia.sv
// memory game presenter: plays ROM entries 0..limite on leds
// each entry: prepare, T_ON lit, T_OFF dark, advance
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON  = T_ON_PADRAO,
  parameter int T_OFF = T_OFF_PADRAO,
  parameter int TMR_W = TMR_W_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  exibe_sequencia_if.slave   bus
);

  estado_t    estado;
  estado_t    proximo;
  logic [3:0] lim_r;
  logic [3:0] endereco_r;
  logic [3:0] leds_r;

  logic [TMR_W-1:0] q_on;
  logic [TMR_W-1:0] q_off;
  logic             fim_on;
  logic             fim_off;
  logic             em_acende;
  logic             em_apaga;
  logic             partida;
  logic             ultimo;

  assign em_acende = (estado == ACENDE);
  assign em_apaga  = (estado == APAGA);
  assign partida   = (estado == INICIAL) && bus.mostrar;
  assign ultimo    = (endereco_r == lim_r);

  exibe_sequencia_temporizador #(
    .M (T_ON),
    .W (TMR_W)
  ) u_tmr_on (
    .clock (clock),
    .reset (reset),
    .zera  (!em_acende),
    .conta (em_acende),
    .q     (q_on),
    .fim   (fim_on)
  );

  exibe_sequencia_temporizador #(
    .M (T_OFF),
    .W (TMR_W)
  ) u_tmr_off (
    .clock (clock),
    .reset (reset),
    .zera  (!em_apaga),
    .conta (em_apaga),
    .q     (q_off),
    .fim   (fim_off)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // next-state decode
  always_comb begin
    proximo = estado;
    unique case (estado)
      INICIAL: if (bus.mostrar) proximo = PREPARA;
      PREPARA: proximo = ACENDE;
      ACENDE:  if (fim_on) proximo = APAGA;
      APAGA:   if (fim_off) proximo = PROXIMO;
      PROXIMO: proximo = ultimo ? FIM : PREPARA;
      FIM:     proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
  end

  // address, limit and led registers
  always_ff @(posedge clock) begin
    if (reset) begin
      lim_r      <= '0;
      endereco_r <= '0;
      leds_r     <= '0;
    end else begin
      unique case (1'b1)
        partida: begin
          lim_r      <= bus.limite;
          endereco_r <= '0;
        end
        (estado == PROXIMO) && !ultimo: begin
          endereco_r <= endereco_r + 4'd1;
        end
        em_acende && (q_on == '0): begin
          leds_r <= bus.dado_mem;
        end
        em_apaga && (q_off == '0): begin
          leds_r <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.endereco  = endereco_r;
  assign bus.leds      = leds_r;
  assign bus.exibindo  = (estado != INICIAL);
  assign bus.pronto    = (estado == FIM);
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// exibe_sequencia bench: scoreboard of lit entries and pronto
// T_ON=3, T_OFF=2, ROM contents 1,2,4,8 repeating
module tb_exibe_sequencia;

  localparam int T_ON  = 3;
  localparam int T_OFF = 2;
  localparam int PER   = T_ON + T_OFF + 2;

  typedef struct {
    int         cyc;
    logic [3:0] val;
    logic [3:0] ende;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  logic [3:0] rom [16];

  exibe_sequencia_if bus ();

  exibe_sequencia #(
    .T_ON  (T_ON),
    .T_OFF (T_OFF),
    .TMR_W (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) bus.dado_mem <= rom[bus.endereco];

  ev_t  q_led [$];
  ev_t  q_pronto [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   on_start = 0;
  logic [3:0] prev_leds = 4'h0;

  function automatic logic [3:0] exp_db(int off, int n);
    int r;
    if (off < 0 || off > PER * n) return 4'h0;
    if (off == PER * n) return 4'hF;
    r = off % PER;
    if (r == 0) return 4'h1;
    if (r <= T_ON) return 4'h2;
    if (r <= T_ON + T_OFF) return 4'h3;
    return 4'h4;
  endfunction

  task automatic push_run(input int k0, input int lim);
    ev_t e;
    for (int i = 0; i <= lim; i++) begin
      e.cyc  = k0 + PER * i + 2;
      e.val  = rom[i];
      e.ende = 4'(i);
      q_led.push_back(e);
    end
    e.cyc  = k0 + PER * (lim + 1);
    e.val  = 4'h0;
    e.ende = 4'(lim);
    q_pronto.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    if (reset) begin
      prev_leds = bus.leds;
      return;
    end
    if (bus.leds !== prev_leds) begin
      if (prev_leds != 4'h0) begin
        n_cmp++;
        if (cyc - on_start != T_ON) begin
          n_err++;
          $display("FAIL led_on_time: got %0d cycles, want %0d",
                   cyc - on_start, T_ON);
        end
      end
      if (bus.leds != 4'h0) begin
        on_start = cyc;
        n_cmp++;
        if (q_led.size() == 0) begin
          n_err++;
          $display("FAIL led_unexpected: leds=%h at cyc %0d, want none",
                   bus.leds, cyc);
        end else begin
          e = q_led.pop_front();
          if (bus.leds !== e.val || cyc != e.cyc ||
              bus.endereco !== e.ende) begin
            n_err++;
            $display("FAIL led_entry: got leds=%h cyc=%0d end=%h, want leds=%h cyc=%0d end=%h",
                     bus.leds, cyc, bus.endereco, e.val, e.cyc, e.ende);
          end
        end
      end
    end
    prev_leds = bus.leds;
    if (bus.pronto === 1'b1) begin
      n_cmp++;
      if (q_pronto.size() == 0) begin
        n_err++;
        $display("FAIL pronto_unexpected: pronto=1 at cyc %0d, want 0", cyc);
      end else begin
        e = q_pronto.pop_front();
        if (cyc != e.cyc || bus.endereco !== e.ende) begin
          n_err++;
          $display("FAIL pronto_time: got cyc=%0d end=%h, want cyc=%0d end=%h",
                   cyc, bus.endereco, e.cyc, e.ende);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    monitor();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q_led.size() != 0 || q_pronto.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (q_led.size() != 0 || q_pronto.size() != 0) begin
      n_err++;
      $display("FAIL run_timeout: pending led=%0d pronto=%0d, want 0/0",
               q_led.size(), q_pronto.size());
      q_led.delete();
      q_pronto.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mostrar = 1'b1;
    bus.limite = 4'h3;
    tick();
    tick();
    n_cmp++;
    if (bus.leds !== 4'h0) begin
      n_err++;
      $display("FAIL reset_leds: got %h, want 0", bus.leds);
    end
    n_cmp++;
    if (bus.endereco !== 4'h0) begin
      n_err++;
      $display("FAIL reset_endereco: got %h, want 0", bus.endereco);
    end
    n_cmp++;
    if (bus.exibindo !== 1'b0 || bus.pronto !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got exib=%b pronto=%b, want 0/0",
               bus.exibindo, bus.pronto);
    end
    n_cmp++;
    if (bus.db_estado !== 4'h0) begin
      n_err++;
      $display("FAIL reset_db: got %h, want 0", bus.db_estado);
    end
    bus.mostrar = 1'b0;
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.exibindo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_start: exibindo=%b, want 0", bus.exibindo);
    end
  endtask

  task automatic test_single();
    int k0;
    bus.limite = 4'h0;
    bus.mostrar = 1'b1;
    k0 = cyc + 1;
    push_run(k0, 0);
    for (int j = 0; j < PER + 3; j++) begin
      tick();
      bus.mostrar = 1'b0;
      n_cmp++;
      if (bus.db_estado !== exp_db(cyc - k0, 1) ||
          bus.exibindo !== (exp_db(cyc - k0, 1) != 4'h0)) begin
        n_err++;
        $display("FAIL single_state: off=%0d got db=%h exib=%b, want db=%h",
                 cyc - k0, bus.db_estado, bus.exibindo, exp_db(cyc - k0, 1));
      end
    end
    wait_idle(10);
  endtask

  task automatic test_sequence();
    bus.limite = 4'h3;
    bus.mostrar = 1'b1;
    push_run(cyc + 1, 3);
    tick();
    bus.mostrar = 1'b0;
    wait_idle(60);
    tick();
  endtask

  task automatic test_ignore();
    bus.limite = 4'h3;
    bus.mostrar = 1'b1;
    push_run(cyc + 1, 3);
    tick();
    bus.mostrar = 1'b0;
    repeat (10) tick();
    bus.mostrar = 1'b1;
    bus.limite = 4'hF;
    repeat (3) tick();
    bus.mostrar = 1'b0;
    wait_idle(60);
    repeat (3) tick();
    n_cmp++;
    if (bus.exibindo !== 1'b0 || bus.endereco !== 4'h3) begin
      n_err++;
      $display("FAIL ignore_end: got exib=%b end=%h, want 0/3",
               bus.exibindo, bus.endereco);
    end
  endtask

  task automatic test_reset_mid();
    int k0;
    bus.limite = 4'h3;
    bus.mostrar = 1'b1;
    k0 = cyc + 1;
    push_run(k0, 3);
    tick();
    bus.mostrar = 1'b0;
    while (cyc < k0 + PER + 2) tick();
    n_cmp++;
    if (bus.leds !== rom[1]) begin
      n_err++;
      $display("FAIL mid_lit: got leds=%h, want %h", bus.leds, rom[1]);
    end
    q_led.delete();
    q_pronto.delete();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.leds !== 4'h0 || bus.exibindo !== 1'b0 ||
        bus.pronto !== 1'b0 || bus.db_estado !== 4'h0 ||
        bus.endereco !== 4'h0) begin
      n_err++;
      $display("FAIL mid_reset: got leds=%h exib=%b pronto=%b db=%h end=%h, want all 0",
               bus.leds, bus.exibindo, bus.pronto, bus.db_estado, bus.endereco);
    end
    reset = 1'b0;
    repeat (PER * 3) tick();
    bus.limite = 4'h1;
    bus.mostrar = 1'b1;
    push_run(cyc + 1, 1);
    tick();
    bus.mostrar = 1'b0;
    wait_idle(40);
    tick();
  endtask

  task automatic test_held();
    int k0;
    int kb;
    bus.limite = 4'hF;
    bus.mostrar = 1'b1;
    k0 = cyc + 1;
    kb = k0 + PER * 16 + 2;
    push_run(k0, 15);
    push_run(kb, 15);
    while (cyc < k0 + PER * 16) tick();
    n_cmp++;
    if (bus.exibindo !== 1'b1 || bus.endereco !== 4'hF) begin
      n_err++;
      $display("FAIL held_fim: got exib=%b end=%h, want 1/F",
               bus.exibindo, bus.endereco);
    end
    tick();
    n_cmp++;
    if (bus.exibindo !== 1'b0) begin
      n_err++;
      $display("FAIL held_gap: got exib=%b, want 0", bus.exibindo);
    end
    tick();
    bus.mostrar = 1'b0;
    n_cmp++;
    if (bus.exibindo !== 1'b1 || bus.endereco !== 4'h0) begin
      n_err++;
      $display("FAIL held_restart: got exib=%b end=%h, want 1/0",
               bus.exibindo, bus.endereco);
    end
    wait_idle(PER * 16 + 20);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    reset = 1'b1;
    bus.mostrar = 1'b0;
    bus.limite = 4'h0;
    test_reset();
    test_single();
    test_sequence();
    test_ignore();
    test_reset_mid();
    test_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
